// File: rtl/fp_minmax_issue_pkg.sv
// rtl/fp_minmax_issue_pkg.sv - shared records and class-bit indices for the min/max issue stage
package fp_minmax_issue_pkg;

    localparam int FP_W    = 32;
    localparam int EXT_W   = 33;
    localparam int CLASS_W = 10;
    localparam int RM_W    = 3;

    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    typedef struct packed {
        logic [FP_W-1:0] data1;
        logic [FP_W-1:0] data2;
        logic [RM_W-1:0] rm;
    } fp_minmax_issue_in_type;

    // Field order matches the min/max unit's input record so it can be assigned whole.
    typedef struct packed {
        logic [FP_W-1:0]    data1;
        logic [FP_W-1:0]    data2;
        logic [EXT_W-1:0]   ext1;
        logic [EXT_W-1:0]   ext2;
        logic [CLASS_W-1:0] class1;
        logic [CLASS_W-1:0] class2;
        logic [RM_W-1:0]    rm;
    } fp_minmax_issue_out_type;

    localparam fp_minmax_issue_out_type OUT_RESET = '0;

endpackage

// File: rtl/fp_minmax_issue_class.sv
// rtl/fp_minmax_issue_class.sv - combinational one-hot classifier and magnitude extender
module fp_class
    import fp_minmax_issue_pkg::*;
(
    input  logic [FP_W-1:0]    data_i,
    output logic [EXT_W-1:0]   ext_o,
    output logic [CLASS_W-1:0] class_o
);

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] mant;
    logic        exp_max;
    logic        exp_zero;
    logic        mant_zero;

    assign sign      = data_i[31];
    assign expo      = data_i[30:23];
    assign mant      = data_i[22:0];
    assign exp_max   = (expo == 8'hFF);
    assign exp_zero  = (expo == 8'h00);
    assign mant_zero = (mant == 23'd0);

    // Zero-padded magnitude keeps unsigned ordering valid across subnormals.
    assign ext_o = {sign, 1'b0, expo, mant};

    always_comb begin
        class_o = '0;
        if (exp_max && !mant_zero) begin
            if (mant[22]) class_o[CLS_QNAN] = 1'b1;
            else          class_o[CLS_SNAN] = 1'b1;
        end else if (exp_max) begin
            if (sign) class_o[CLS_NEG_INF] = 1'b1;
            else      class_o[CLS_POS_INF] = 1'b1;
        end else if (exp_zero && mant_zero) begin
            if (sign) class_o[CLS_NEG_ZERO] = 1'b1;
            else      class_o[CLS_POS_ZERO] = 1'b1;
        end else if (exp_zero) begin
            if (sign) class_o[CLS_NEG_SUB] = 1'b1;
            else      class_o[CLS_POS_SUB] = 1'b1;
        end else begin
            if (sign) class_o[CLS_NEG_NORM] = 1'b1;
            else      class_o[CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_minmax_issue.sv
// rtl/fp_minmax_issue.sv - operand classification with a 2-entry skid buffer ahead of min/max
module fp_minmax_issue
    import fp_minmax_issue_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FP_W-1:0]    in_data1,
    input  logic [FP_W-1:0]    in_data2,
    input  logic [RM_W-1:0]    in_rm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_W-1:0]    out_data1,
    output logic [FP_W-1:0]    out_data2,
    output logic [EXT_W-1:0]   out_ext1,
    output logic [EXT_W-1:0]   out_ext2,
    output logic [CLASS_W-1:0] out_class1,
    output logic [CLASS_W-1:0] out_class2,
    output logic [RM_W-1:0]    out_rm
);

    localparam int HEAD  = 0;
    localparam int SPARE = 1;

    // The canonical NaN is consumed downstream; reduce it here so it stays visible in the hierarchy.
    logic unused_nan_canon;
    assign unused_nan_canon = ^NAN_CANON;

    fp_minmax_issue_in_type  in_rec;
    fp_minmax_issue_out_type new_rec;
    fp_minmax_issue_out_type head_q,  head_d;
    fp_minmax_issue_out_type spare_q, spare_d;
    logic [DEPTH-1:0]        vld_q,   vld_d;
    logic                    in_xfer;
    logic                    out_xfer;

    assign in_rec = '{data1: in_data1, data2: in_data2, rm: in_rm};

    fp_class u_class1 (
        .data_i  (in_rec.data1),
        .ext_o   (new_rec.ext1),
        .class_o (new_rec.class1)
    );

    fp_class u_class2 (
        .data_i  (in_rec.data2),
        .ext_o   (new_rec.ext2),
        .class_o (new_rec.class2)
    );

    assign new_rec.data1 = in_rec.data1;
    assign new_rec.data2 = in_rec.data2;
    assign new_rec.rm    = in_rec.rm;

    // Ready comes only from the spare flag so out_ready never reaches in_ready combinationally.
    assign in_ready = ~vld_q[SPARE];
    assign in_xfer  = in_valid & ~vld_q[SPARE];
    assign out_xfer = vld_q[HEAD] & out_ready;

    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        vld_d   = vld_q;
        case ({in_xfer, out_xfer})
            2'b10: begin
                if (!vld_q[HEAD]) begin
                    head_d      = new_rec;
                    vld_d[HEAD] = 1'b1;
                end else begin
                    spare_d      = new_rec;
                    vld_d[SPARE] = 1'b1;
                end
            end
            2'b01: begin
                if (vld_q[SPARE]) begin
                    head_d       = spare_q;
                    spare_d      = OUT_RESET;
                    vld_d[SPARE] = 1'b0;
                end else begin
                    // Clearing the record keeps out_class at zero whenever out_valid is low.
                    head_d      = OUT_RESET;
                    vld_d[HEAD] = 1'b0;
                end
            end
            2'b11: begin
                head_d = new_rec;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= OUT_RESET;
            spare_q <= OUT_RESET;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            spare_q <= spare_d;
            vld_q   <= vld_d;
        end
    end

    assign out_valid  = vld_q[HEAD];
    assign out_data1  = head_q.data1;
    assign out_data2  = head_q.data2;
    assign out_ext1   = head_q.ext1;
    assign out_ext2   = head_q.ext2;
    assign out_class1 = head_q.class1;
    assign out_class2 = head_q.class2;
    assign out_rm     = head_q.rm;

endmodule

// File: tb/tb_fp_minmax_issue.sv
// tb/tb_fp_minmax_issue.sv - randomized self-checking bench for fp_minmax_issue
module tb_fp_minmax_issue;

    typedef logic [152:0] vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data1;
    logic [31:0] in_data2;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [32:0] out_ext1;
    logic [32:0] out_ext2;
    logic [9:0]  out_class1;
    logic [9:0]  out_class2;
    logic [2:0]  out_rm;

    vec_t got;
    vec_t q[$];
    int   total = 0;
    int   bad   = 0;

    fp_minmax_issue dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_ext1   (out_ext1),
        .out_ext2   (out_ext2),
        .out_class1 (out_class1),
        .out_class2 (out_class2),
        .out_rm     (out_rm)
    );

    always #5 clock = ~clock;

    assign got = {out_data1, out_data2, out_ext1, out_ext2, out_class1, out_class2, out_rm};

    function automatic logic [9:0] ref_class(input logic [31:0] a);
        int e;
        int m;
        int cat;
        int idx;
        e = int'(a[30:23]);
        m = int'(a[22:0]);
        if (e == 255 && m != 0) begin
            idx = (m >= (1 << 22)) ? 9 : 8;
        end else begin
            if (e == 255)               cat = 3;
            else if (e == 0 && m == 0)  cat = 0;
            else if (e == 0)            cat = 1;
            else                        cat = 2;
            idx = a[31] ? (3 - cat) : (4 + cat);
        end
        return 10'(1) << idx;
    endfunction

    function automatic vec_t ref_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic [32:0] ea;
        logic [32:0] eb;
        ea = {a[31], 1'b0, a[30:0]};
        eb = {b[31], 1'b0, b[30:0]};
        return {a, b, ea, eb, ref_class(a), ref_class(b), rm};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[30:23] = 8'hFF;
            1: r[30:23] = 8'h00;
            2: r[30:0]  = 31'd0;
            3: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick();
        logic acc;
        logic pop;
        vec_t nv;
        acc = in_valid && (q.size() < 2);
        pop = out_ready && (q.size() > 0);
        nv  = ref_vec(in_data1, in_data2, in_rm);
        @(posedge clock);
        #1;
        if (reset) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(nv);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data1 = '0; in_data2 = '0; in_rm = '0;
        tick(); tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (got !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", got); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data1 = 32'h3F800000; in_data2 = 32'hBF800000; in_rm = 3'd1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_class1 !== 10'h040) begin bad++; $display("FAIL basic_class1 got=%h exp=040", out_class1); end
        total++; if (out_class2 !== 10'h002) begin bad++; $display("FAIL basic_class2 got=%h exp=002", out_class2); end
        total++; if (out_ext1 !== 33'h03F800000) begin bad++; $display("FAIL basic_ext1 got=%h exp=03F800000", out_ext1); end
        total++; if (out_ext2 !== 33'h13F800000) begin bad++; $display("FAIL basic_ext2 got=%h exp=13F800000", out_ext2); end
        total++; if (out_rm !== 3'd1 || out_data1 !== 32'h3F800000 || out_data2 !== 32'hBF800000) begin
            bad++; $display("FAIL basic_pass got=%h/%h/%h exp=1/3F800000/BF800000", out_rm, out_data1, out_data2);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_special();
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [9:0]  ca[4];
        logic [9:0]  cb[4];
        a  = '{32'h7F800001, 32'h80000000, 32'hFF800000, 32'h807FFFFF};
        b  = '{32'h7FC00000, 32'h00000001, 32'h7F800000, 32'h00000000};
        ca = '{10'h100, 10'h008, 10'h001, 10'h004};
        cb = '{10'h200, 10'h020, 10'h080, 10'h010};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data1 = a[i]; in_data2 = b[i]; in_rm = 3'(i + 2);
            tick();
            in_valid = 1'b0;
            total++; if (out_class1 !== ca[i] || out_class2 !== cb[i]) begin
                bad++; $display("FAIL special_class[%0d] got=%h/%h exp=%h/%h", i, out_class1, out_class2, ca[i], cb[i]);
            end
            total++; if (out_rm !== 3'(i + 2)) begin bad++; $display("FAIL special_rm[%0d] got=%0d exp=%0d", i, out_rm, i + 2); end
            total++; if (q.size() == 0 || got !== q[0]) begin bad++; $display("FAIL special_rec[%0d] got=%h", i, got); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        vec_t r[3];
        logic [31:0] da[3];
        logic [31:0] db[3];
        logic [2:0]  dr[3];
        for (int i = 0; i < 3; i++) begin
            da[i] = rand_fp(); db[i] = rand_fp(); dr[i] = 3'($urandom);
            r[i]  = ref_vec(da[i], db[i], dr[i]);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data1 = da[i]; in_data2 = db[i]; in_rm = dr[i];
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_accept[%0d] got=%b exp=1", i, in_ready); end
            tick();
        end
        in_data1 = da[2]; in_data2 = db[2]; in_rm = dr[2];
        for (int k = 0; k < 3; k++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full[%0d] got=%b exp=0", k, in_ready); end
            total++; if (out_valid !== 1'b1 || got !== r[0]) begin bad++; $display("FAIL bp_stall[%0d] got=%h exp=%h", k, got, r[0]); end
            if (k < 2) tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b1 || got !== r[k]) begin bad++; $display("FAIL drain_order[%0d] got=%h exp=%h", k, got, r[k]); end
            tick();
            if (k == 1) in_valid = 1'b0;
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        vec_t prev;
        prev = '0;
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                in_valid = 1'b1; in_data1 = rand_fp(); in_data2 = rand_fp(); in_rm = 3'($urandom);
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                total++; if (out_valid !== 1'b1 || got !== prev) begin bad++; $display("FAIL stream_out[%0d] got=%h exp=%h", i, got, prev); end
            end
            prev = ref_vec(in_data1, in_data2, in_rm);
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data1  = rand_fp(); in_data2 = rand_fp(); in_rm = 3'($urandom);
            total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, q.size() != 0); end
            total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, q.size() < 2); end
            if (q.size() != 0) begin
                total++; if (got !== q[0]) begin bad++; $display("FAIL rand_rec[%0d] got=%h exp=%h", i, got, q[0]); end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data1 = rand_fp(); in_data2 = rand_fp(); in_rm = 3'($urandom);
            tick();
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", in_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset got=valid %b ready %b exp=valid 0 ready 1", out_valid, in_ready);
        end
        total++; if (got !== '0) begin bad++; $display("FAIL mid_data got=%h exp=0", got); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_ghost[%0d] got=%b exp=0", i, out_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_backpressure();
        test_stream();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
